regfile_seq: RTL and testbench

REGFILE_SEQ -- requirements
Module: regfile_seq

---
 rtl/regfile_seq.sv | 177 +++++++++++++++++
 tb/tb_regfile_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// regfile_seq: command sequencer that drives a single-port register file.
// Executes LDI / MOV / RD / ADDA through IDLE -> READ -> WRITE -> RESP steps.
// Every output is registered. The next-state logic decodes the next output
// values from the next state, so each output is valid for the whole cycle
// that its state occupies.
module regfile_seq #(
  parameter int unsigned ACC_ADDR  = 0,
  parameter int unsigned ZERO_ADDR = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_dst,
  input  logic [3:0] cmd_src,
  input  logic [7:0] cmd_imm,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       we_reg,
  output logic [3:0] addr_reg,
  output logic [7:0] data_reg,
  input  logic [7:0] out_reg,
  input  logic [7:0] ACC
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  localparam logic [AW-1:0] ACC_A  = AW'(ACC_ADDR);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_MOV  = 2'b01,
    OP_RD   = 2'b10,
    OP_ADDA = 2'b11
  } op_t;

  state_t        state, state_nxt;
  op_t           op_q, op_nxt;
  logic [AW-1:0] dst_q, dst_nxt;
  logic [AW-1:0] src_q, src_nxt;
  logic [DW-1:0] imm_q, imm_nxt;
  logic [DW-1:0] val_q, val_nxt;
  logic [DW-1:0] acc_q, acc_nxt;

  logic          ready_nxt;
  logic          valid_nxt;
  logic          we_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] data_nxt;
  logic [DW-1:0] rdata_nxt;
  logic          carry_nxt;

  logic [DW:0]   sum_nxt;
  logic [AW-1:0] target_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [DW-1:0] result_nxt;

  // Next state, latched command fields, and the registered outputs of the next state
  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    dst_nxt    = dst_q;
    src_nxt    = src_q;
    imm_nxt    = imm_q;
    val_nxt    = val_q;
    acc_nxt    = acc_q;
    ready_nxt  = 1'b0;
    valid_nxt  = 1'b0;
    we_nxt     = 1'b0;
    addr_nxt   = '0;
    data_nxt   = '0;
    rdata_nxt  = rsp_data;
    carry_nxt  = rsp_carry;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_nxt    = op_t'(cmd_op);
          dst_nxt   = cmd_dst;
          src_nxt   = cmd_src;
          imm_nxt   = cmd_imm;
          state_nxt = (op_t'(cmd_op) == OP_LDI) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        val_nxt   = (src_q == ZERO_A) ? '0 : out_reg;
        acc_nxt   = ACC;
        state_nxt = (op_q == OP_RD) ? S_RESP : S_WRITE;
      end
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Datapath results are derived from the fields as they stand in the next state
    sum_nxt    = {1'b0, acc_nxt} + {1'b0, val_nxt};
    target_nxt = (op_nxt == OP_ADDA) ? ACC_A : dst_nxt;
    case (op_nxt)
      OP_LDI:  wdata_nxt = imm_nxt;
      OP_MOV:  wdata_nxt = val_nxt;
      OP_ADDA: wdata_nxt = sum_nxt[DW-1:0];
      default: wdata_nxt = '0;
    endcase
    case (op_nxt)
      OP_LDI:  result_nxt = imm_nxt;
      OP_ADDA: result_nxt = sum_nxt[DW-1:0];
      default: result_nxt = val_nxt;
    endcase

    case (state_nxt)
      S_IDLE: ready_nxt = 1'b1;
      S_READ: addr_nxt  = src_nxt;
      S_WRITE: begin
        addr_nxt = target_nxt;
        data_nxt = wdata_nxt;
        we_nxt   = (target_nxt != ZERO_A);
      end
      S_RESP: begin
        valid_nxt = 1'b1;
        // The response is loaded only on entry to RESP and held until the handshake
        if (state != S_RESP) begin
          rdata_nxt = result_nxt;
          carry_nxt = (op_nxt == OP_ADDA) && sum_nxt[DW];
        end
      end
      default: ready_nxt = 1'b0;
    endcase
  end

  // State, latched fields and registered outputs; reset clears them without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_LDI;
      dst_q     <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      val_q     <= '0;
      acc_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      dst_q     <= dst_nxt;
      src_q     <= src_nxt;
      imm_q     <= imm_nxt;
      val_q     <= val_nxt;
      acc_q     <= acc_nxt;
      cmd_ready <= ready_nxt;
      rsp_valid <= valid_nxt;
      rsp_data  <= rdata_nxt;
      rsp_carry <= carry_nxt;
      we_reg    <= we_nxt;
      addr_reg  <= addr_nxt;
      data_reg  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: directed vector table plus hand sequences for regfile_seq.
// The bench holds a 16x8 register file that the DUT reads and writes.
module tb_regfile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_dst;
  logic [3:0] cmd_src;
  logic [7:0] cmd_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       we_reg;
  logic [3:0] addr_reg;
  logic [7:0] data_reg;
  logic [7:0] out_reg;
  logic [7:0] acc;

  logic [7:0] rf [16] = '{default: 8'h00};
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = 4'd0;
  logic [7:0] pre_data = 8'd0;

  int checks = 0;
  int errors = 0;

  regfile_seq #(.ACC_ADDR(0), .ZERO_ADDR(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .we_reg(we_reg), .addr_reg(addr_reg), .data_reg(data_reg),
    .out_reg(out_reg), .ACC(acc)
  );

  always #5 clk = ~clk;

  // Register-file model: combinational read, write on the rising edge
  assign out_reg = rf[addr_reg];
  assign acc     = rf[0];
  always @(posedge clk) begin
    if (we_reg) rf[addr_reg] <= data_reg;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one command and observes it until the response is visible
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                        input logic [7:0] imm,
                        output logic [7:0] g_data, output logic g_carry, output int g_lat,
                        output int g_wes, output logic [3:0] g_waddr, output logic [7:0] g_wdata,
                        output logic [3:0] g_addr1);
    g_data = '0; g_carry = 1'b0; g_lat = 0; g_wes = 0; g_waddr = '0; g_wdata = '0; g_addr1 = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 1) g_addr1 = addr_reg;
      if (we_reg) begin
        g_wes++;
        g_waddr = addr_reg;
        g_wdata = data_reg;
      end
      if (rsp_valid) begin
        g_lat = cyc; g_data = rsp_data; g_carry = rsp_carry;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] imm;
    logic [7:0] data;
    logic       carry;
    int         lat;
    int         wes;
    logic [3:0] waddr;
    logic [7:0] wdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                              input logic [7:0] imm, input logic [7:0] data, input logic carry,
                              input int lat, input int wes, input logic [3:0] waddr,
                              input logic [7:0] wdata);
    vec_t v;
    v.op = op; v.dst = dst; v.src = src; v.imm = imm; v.data = data; v.carry = carry;
    v.lat = lat; v.wes = wes; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    logic [7:0] g_data;
    logic       g_carry;
    int         g_lat;
    int         g_wes;
    logic [3:0] g_waddr;
    logic [7:0] g_wdata;
    logic [3:0] g_addr1;
    logic [7:0] held;
    bit         seen;

    // op dst src imm | data carry lat wes waddr wdata
    tbl[0]  = mk(2'b00, 4'd2,  4'd0,  8'h5A, 8'h5A, 1'b0, 2, 1, 4'd2, 8'h5A);
    tbl[1]  = mk(2'b01, 4'd3,  4'd2,  8'h00, 8'h5A, 1'b0, 3, 1, 4'd3, 8'h5A);
    tbl[2]  = mk(2'b00, 4'd1,  4'd0,  8'h20, 8'h20, 1'b0, 2, 1, 4'd1, 8'h20);
    tbl[3]  = mk(2'b00, 4'd0,  4'd0,  8'hF0, 8'hF0, 1'b0, 2, 1, 4'd0, 8'hF0);
    tbl[4]  = mk(2'b11, 4'd0,  4'd1,  8'h00, 8'h10, 1'b1, 3, 1, 4'd0, 8'h10);
    tbl[5]  = mk(2'b11, 4'd0,  4'd0,  8'h00, 8'h20, 1'b0, 3, 1, 4'd0, 8'h20);
    tbl[6]  = mk(2'b00, 4'd15, 4'd0,  8'h33, 8'h33, 1'b0, 2, 0, 4'd0, 8'h00);
    tbl[7]  = mk(2'b10, 4'd0,  4'd15, 8'h00, 8'h00, 1'b0, 2, 0, 4'd0, 8'h00);
    tbl[8]  = mk(2'b01, 4'd3,  4'd3,  8'h00, 8'h5A, 1'b0, 3, 1, 4'd3, 8'h5A);
    tbl[9]  = mk(2'b10, 4'd0,  4'd3,  8'h00, 8'h5A, 1'b0, 2, 0, 4'd0, 8'h00);
    tbl[10] = mk(2'b01, 4'd15, 4'd2,  8'h00, 8'h5A, 1'b0, 3, 0, 4'd0, 8'h00);
    tbl[11] = mk(2'b11, 4'd0,  4'd15, 8'h00, 8'h20, 1'b0, 3, 1, 4'd0, 8'h20);
    tbl[12] = mk(2'b00, 4'd4,  4'd0,  8'h81, 8'h81, 1'b0, 2, 1, 4'd4, 8'h81);
    tbl[13] = mk(2'b00, 4'd0,  4'd0,  8'hFF, 8'hFF, 1'b0, 2, 1, 4'd0, 8'hFF);
    tbl[14] = mk(2'b11, 4'd0,  4'd0,  8'h00, 8'hFE, 1'b1, 3, 1, 4'd0, 8'hFE);

    cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_rsp_data",  16'(rsp_data),  16'h0);
    check("rst_rsp_carry", 16'(rsp_carry), 16'h0);
    check("rst_we_reg",    16'(we_reg),    16'h0);
    check("rst_addr_reg",  16'(addr_reg),  16'h0);
    check("rst_data_reg",  16'(data_reg),  16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Register 15 holds a nonzero value that reads must ignore
    preload(4'd15, 8'hAA);

    for (int i = 0; i < 15; i++) begin
      do_cmd(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm,
             g_data, g_carry, g_lat, g_wes, g_waddr, g_wdata, g_addr1);
      check($sformatf("v%0d_lat", i),   16'(g_lat),   16'(tbl[i].lat));
      check($sformatf("v%0d_data", i),  16'(g_data),  16'(tbl[i].data));
      check($sformatf("v%0d_carry", i), 16'(g_carry), 16'(tbl[i].carry));
      check($sformatf("v%0d_wes", i),   16'(g_wes),   16'(tbl[i].wes));
      check($sformatf("v%0d_addr1", i), 16'(g_addr1),
            16'((tbl[i].op == 2'b00) ? tbl[i].dst : tbl[i].src));
      if (tbl[i].wes == 1) begin
        check($sformatf("v%0d_waddr", i), 16'(g_waddr), 16'(tbl[i].waddr));
        check($sformatf("v%0d_wdata", i), 16'(g_wdata), 16'(tbl[i].wdata));
      end
      // Handshake completes at the next edge; the sequencer is ready right after
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready_after", i), 16'(cmd_ready), 16'h1);
      check($sformatf("v%0d_valid_after", i), 16'(rsp_valid), 16'h0);
    end

    // Response stall: RD src=4 held for 5 cycles with rsp_ready low
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dst = 4'd0; cmd_src = 4'd4; cmd_imm = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    check("stall_rsp_seen", 16'(seen), 16'h1);
    held = rsp_data;
    check("stall_data", 16'(held), 16'h81);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_valid_hold", 16'(rsp_valid), 16'h1);
      check("stall_data_hold",  16'(rsp_data),  16'h81);
      check("stall_not_ready",  16'(cmd_ready), 16'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_ready_after", 16'(cmd_ready), 16'h1);
    check("stall_valid_after", 16'(rsp_valid), 16'h0);

    // Asynchronous reset during the WRITE cycle of a MOV src=2 dst=5
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_dst = 4'd5; cmd_src = 4'd2; cmd_imm = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_we_before", 16'(we_reg), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("abort_we_async",    16'(we_reg),    16'h0);
    check("abort_valid_async", 16'(rsp_valid), 16'h0);
    check("abort_ready_async", 16'(cmd_ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 16'(seen), 16'h0);
    check("abort_ready_release", 16'(cmd_ready), 16'h1);

    // The aborted MOV must not have written register 5
    do_cmd(2'b10, 4'd0, 4'd5, 8'h00, g_data, g_carry, g_lat, g_wes, g_waddr, g_wdata, g_addr1);
    check("abort_r5_data", 16'(g_data), 16'h00);
    check("abort_r5_lat",  16'(g_lat),  16'd2);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
